// File: rtl/fft_stage_sequencer.sv
// Issue/write-back address sequencer for an in-place radix-2 DIT FFT over one data RAM.
// Optional FFT_SCALE_ALL_EN: scale every stage instead of odd stages only.
module fft_stage_sequencer #(
    parameter int unsigned FFT_SIZE     = 4096,
    parameter int unsigned RD_LATENCY   = 1,
    parameter int unsigned BFLY_LATENCY = 5,
    localparam int unsigned LOG2N       = $clog2(FFT_SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [LOG2N-1:0] stage,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addra,
    output logic [LOG2N-1:0] rd_addrb,
    output logic [LOG2N-2:0] twiddle_addr,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addra,
    output logic [LOG2N-1:0] wr_addrb,
    output logic             scale
);

    localparam int unsigned PIPE = RD_LATENCY + BFLY_LATENCY;
    localparam int unsigned KW   = LOG2N - 1;
    localparam int unsigned CW   = (PIPE > 1) ? $clog2(PIPE) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic             en;
        logic [LOG2N-1:0] addra;
        logic [LOG2N-1:0] addrb;
        logic             scale;
    } wb_t;

    state_t             state_q, state_d;
    logic [KW-1:0]      k_q, k_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [LOG2N-1:0]   stg_q, stg_d;

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [LOG2N-1:0]   stage_out_q, stage_out_d;
    logic               rd_en_q, rd_en_d;
    logic [LOG2N-1:0]   rd_addra_q, rd_addra_d;
    logic [LOG2N-1:0]   rd_addrb_q, rd_addrb_d;
    logic [LOG2N-2:0]   twiddle_q, twiddle_d;
    logic               scale_iss_q, scale_iss_d;
    wb_t [PIPE-1:0]     pipe_q, pipe_d;

    logic [LOG2N-1:0]   k_ext_c, mask_c, pos_c, grp_c, addra_c, addrb_c;
    logic [LOG2N-2:0]   tw_c;
    logic               scale_bit_c;
    logic               issue_c;

    // Butterfly address generation for stage stg_q, butterfly k_q
    always_comb begin
        k_ext_c = LOG2N'(k_q);
        mask_c  = (LOG2N'(1) << stg_q) - LOG2N'(1);
        pos_c   = k_ext_c & mask_c;
        grp_c   = k_ext_c >> stg_q;
        addra_c = (grp_c << (32'(stg_q) + 32'd1)) | pos_c;
        addrb_c = addra_c | (LOG2N'(1) << stg_q);
        tw_c    = (LOG2N-1)'(pos_c << (LOG2N - 32'd1 - 32'(stg_q)));
    end

`ifdef FFT_SCALE_ALL_EN
    assign scale_bit_c = 1'b1;
`else
    assign scale_bit_c = stg_q[0];
`endif

    assign issue_c = (state_q == RUN);

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        stg_d       = stg_q;

        busy_d      = (state_q != IDLE);
        done_d      = (state_q == DONE);
        stage_out_d = stg_q;
        rd_en_d     = issue_c;
        rd_addra_d  = issue_c ? addra_c : '0;
        rd_addrb_d  = issue_c ? addrb_c : '0;
        twiddle_d   = issue_c ? tw_c : '0;
        scale_iss_d = issue_c & scale_bit_c;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    k_d     = '0;
                    stg_d   = '0;
                end
            end
            RUN: begin
                k_d = k_q + KW'(1);
                if (k_q == KW'(FFT_SIZE / 2 - 1)) begin
                    k_d   = '0;
                    cnt_d = '0;
                    if (stg_q == LOG2N'(LOG2N - 1)) begin
                        state_d = FLUSH;
                        stg_d   = '0;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(PIPE - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    stg_d   = stg_q + LOG2N'(1);
                end
            end
            FLUSH: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(PIPE - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Write-back delay line: issue outputs delayed PIPE cycles, zeroed when idle
    always_comb begin
        pipe_d[0].en    = rd_en_q;
        pipe_d[0].addra = rd_en_q ? rd_addra_q : '0;
        pipe_d[0].addrb = rd_en_q ? rd_addrb_q : '0;
        pipe_d[0].scale = rd_en_q & scale_iss_q;
        for (int i = 1; i < int'(PIPE); i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            cnt_q       <= '0;
            stg_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stage_out_q <= '0;
            rd_en_q     <= 1'b0;
            rd_addra_q  <= '0;
            rd_addrb_q  <= '0;
            twiddle_q   <= '0;
            scale_iss_q <= 1'b0;
            pipe_q      <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            stg_q       <= stg_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            stage_out_q <= stage_out_d;
            rd_en_q     <= rd_en_d;
            rd_addra_q  <= rd_addra_d;
            rd_addrb_q  <= rd_addrb_d;
            twiddle_q   <= twiddle_d;
            scale_iss_q <= scale_iss_d;
            pipe_q      <= pipe_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign stage        = stage_out_q;
    assign rd_en        = rd_en_q;
    assign rd_addra     = rd_addra_q;
    assign rd_addrb     = rd_addrb_q;
    assign twiddle_addr = twiddle_q;
    assign wr_en        = pipe_q[PIPE-1].en;
    assign wr_addra     = pipe_q[PIPE-1].addra;
    assign wr_addrb     = pipe_q[PIPE-1].addrb;
    assign scale        = pipe_q[PIPE-1].scale;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer at FFT_SIZE=16 (PIPE=6); honours FFT_SCALE_ALL_EN.
module tb_fft_stage_sequencer;

    localparam int N        = 16;
    localparam int LOG2N    = 4;
    localparam int HALF     = N / 2;
    localparam int PIPE     = 6;
    localparam int DONE_CYC = LOG2N * (HALF + PIPE) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             busy, done, rd_en, wr_en, scale;
    logic [LOG2N-1:0] stage, rd_addra, rd_addrb, wr_addra, wr_addrb;
    logic [LOG2N-2:0] twiddle_addr;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int cyc;
        int a;
        int b;
        int tw;
        int stg;
        bit sc;
    } exp_t;

    exp_t rd_q[$];
    exp_t wr_q[$];

    fft_stage_sequencer #(
        .FFT_SIZE    (N),
        .RD_LATENCY  (1),
        .BFLY_LATENCY(5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .stage       (stage),
        .rd_en       (rd_en),
        .rd_addra    (rd_addra),
        .rd_addrb    (rd_addrb),
        .twiddle_addr(twiddle_addr),
        .wr_en       (wr_en),
        .wr_addra    (wr_addra),
        .wr_addrb    (wr_addrb),
        .scale       (scale)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected transform built group-by-group, position-by-position
    task automatic push_model();
        exp_t e;
        int   c;
        int   half;
        c = 1;
        for (int s = 0; s < LOG2N; s++) begin
            half = 1 << s;
            for (int g = 0; g < N / (2 * half); g++) begin
                for (int p = 0; p < half; p++) begin
                    e.cyc = c;
                    e.a   = g * 2 * half + p;
                    e.b   = e.a + half;
                    e.tw  = p * (HALF / half);
                    e.stg = s;
`ifdef FFT_SCALE_ALL_EN
                    e.sc  = 1'b1;
`else
                    e.sc  = (s % 2) == 1;
`endif
                    rd_q.push_back(e);
                    e.cyc = c + PIPE;
                    wr_q.push_back(e);
                    c++;
                end
            end
            c += PIPE;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy, done, stage} !== '0)
            begin errors++; $display("FAIL reset_ctrl: busy=%b done=%b stage=%0d, want all 0", busy, done, stage); end
        checks++;
        if ({rd_en, rd_addra, rd_addrb, twiddle_addr} !== '0)
            begin errors++; $display("FAIL reset_issue: rd_en=%b a=%0d b=%0d tw=%0d, want all 0", rd_en, rd_addra, rd_addrb, twiddle_addr); end
        checks++;
        if ({wr_en, wr_addra, wr_addrb, scale} !== '0)
            begin errors++; $display("FAIL reset_wb: wr_en=%b a=%0d b=%0d scale=%b, want all 0", wr_en, wr_addra, wr_addrb, scale); end
        rst = 1'b0;
        for (int n = 0; n < PIPE + 2; n++) begin
            tick();
            checks++;
            if (wr_en !== 1'b0 || busy !== 1'b0)
                begin errors++; $display("FAIL reset_quiet: n=%0d wr_en=%b busy=%b, want 0 0", n, wr_en, busy); end
        end
    endtask

    task automatic test_full_run(input string tag);
        exp_t e;
        int   n_rd = 0;
        int   n_wr = 0;
        int   n_done = 0;
        bit   exp_busy;
        rd_q.delete();
        wr_q.delete();
        push_model();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < DONE_CYC + 15; n++) begin
            if (n != 0) tick();
            exp_busy = (n >= 1) && (n <= DONE_CYC);
            checks++;
            if (busy !== exp_busy)
                begin errors++; $display("FAIL %s busy: n=%0d got %b want %b", tag, n, busy, exp_busy); end
            if (done === 1'b1) begin
                n_done++;
                checks++;
                if (n != DONE_CYC)
                    begin errors++; $display("FAIL %s done_cycle: got %0d want %0d", tag, n, DONE_CYC); end
            end
            if (rd_en === 1'b1) begin
                n_rd++;
                checks++;
                if (rd_q.size() == 0) begin
                    errors++; $display("FAIL %s extra_issue: n=%0d a=%0d b=%0d", tag, n, rd_addra, rd_addrb);
                end else begin
                    e = rd_q.pop_front();
                    if (n != e.cyc || int'(rd_addra) != e.a || int'(rd_addrb) != e.b ||
                        int'(twiddle_addr) != e.tw || int'(stage) != e.stg)
                        begin errors++; $display("FAIL %s issue: got n=%0d a=%0d b=%0d tw=%0d stg=%0d want n=%0d a=%0d b=%0d tw=%0d stg=%0d",
                            tag, n, rd_addra, rd_addrb, twiddle_addr, stage, e.cyc, e.a, e.b, e.tw, e.stg); end
                end
            end
            checks++;
            if (wr_en === 1'b1) begin
                n_wr++;
                if (wr_q.size() == 0) begin
                    errors++; $display("FAIL %s extra_write: n=%0d a=%0d b=%0d", tag, n, wr_addra, wr_addrb);
                end else begin
                    e = wr_q.pop_front();
                    if (n != e.cyc || int'(wr_addra) != e.a || int'(wr_addrb) != e.b || scale !== e.sc)
                        begin errors++; $display("FAIL %s write: got n=%0d a=%0d b=%0d sc=%b want n=%0d a=%0d b=%0d sc=%b",
                            tag, n, wr_addra, wr_addrb, scale, e.cyc, e.a, e.b, e.sc); end
                end
            end else if ({wr_addra, wr_addrb, scale} !== '0) begin
                errors++; $display("FAIL %s idle_wb: n=%0d a=%0d b=%0d sc=%b want 0", tag, n, wr_addra, wr_addrb, scale);
            end
        end
        checks++;
        if (n_rd != N / 2 * LOG2N || n_wr != N / 2 * LOG2N || n_done != 1)
            begin errors++; $display("FAIL %s counts: rd=%0d wr=%0d done=%0d want %0d %0d 1", tag, n_rd, n_wr, n_done, N / 2 * LOG2N, N / 2 * LOG2N); end
        checks++;
        if (rd_q.size() != 0 || wr_q.size() != 0)
            begin errors++; $display("FAIL %s leftover: rd=%0d wr=%0d want 0 0", tag, rd_q.size(), wr_q.size()); end
    endtask

    task automatic test_ignore_start();
        int n_rd = 0;
        int n_wr = 0;
        int n_done = 0;
        int done_at = -1;
        int late_rd = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n < 2 * DONE_CYC + 10; n++) begin
            start = (n == 5) || (n == DONE_CYC);
            tick();
            start = 1'b0;
            if (rd_en === 1'b1) n_rd++;
            if (rd_en === 1'b1 && n > DONE_CYC) late_rd++;
            if (wr_en === 1'b1) n_wr++;
            if (done === 1'b1) begin n_done++; done_at = n; end
        end
        checks++;
        if (n_done != 1 || done_at != DONE_CYC)
            begin errors++; $display("FAIL ignore_done: pulses=%0d at=%0d want 1 at %0d", n_done, done_at, DONE_CYC); end
        checks++;
        if (n_rd != N / 2 * LOG2N || n_wr != N / 2 * LOG2N)
            begin errors++; $display("FAIL ignore_counts: rd=%0d wr=%0d want %0d", n_rd, n_wr, N / 2 * LOG2N); end
        checks++;
        if (late_rd != 0 || busy !== 1'b0)
            begin errors++; $display("FAIL ignore_rerun: late_rd=%0d busy=%b want 0 0", late_rd, busy); end
    endtask

    task automatic test_mid_reset();
        int stray = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n < 20; n++) tick();
        checks++;
        if (rd_en !== 1'b1 || stage !== 4'd1)
            begin errors++; $display("FAIL midrst_pre: rd_en=%b stage=%0d want 1 1", rd_en, stage); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, done, stage, rd_en, rd_addra, rd_addrb, twiddle_addr, wr_en, wr_addra, wr_addrb, scale} !== '0)
            begin errors++; $display("FAIL midrst_zero: busy=%b rd_en=%b a=%0d wr_en=%b wa=%0d stage=%0d want all 0",
                busy, rd_en, rd_addra, wr_en, wr_addra, stage); end
        for (int n = 0; n < 3 * PIPE; n++) begin
            tick();
            if (wr_en !== 1'b0 || rd_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0)
            begin errors++; $display("FAIL midrst_quiet: %0d active cycles after reset, want 0", stray); end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        test_reset();
        test_full_run("full");
        test_ignore_start();
        test_mid_reset();
        test_full_run("restart");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
